// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester, transmitter and status signals around the UART TX arbiter.
// The master modport is the arbiter's view; the slave modport is its environment.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           grant;
  logic [DATA_BITS-1:0]         tx_data;
  logic                         tx_start;
  logic                         tx_done_tick;
  logic                         busy;
  logic [IDW-1:0]               grant_id;
  logic                         err_timeout;
  logic                         err_clr;

  modport master (
    input  req, req_data, tx_done_tick, err_clr,
    output grant, tx_data, tx_start, busy, grant_id, err_timeout
  );

  modport slave (
    output req, req_data, tx_done_tick, err_clr,
    input  grant, tx_data, tx_start, busy, grant_id, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte producers,
// with a watchdog that flags a hung transmitter through a sticky error.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  uart_tx_arbiter_if.master bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 busy_q, busy_d;
  logic [IDW-1:0]       grant_id_q, grant_id_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [IDW-1:0]       sel;
  logic                 found;
  logic                 timeout;
  int                   idx;

  // Scan starts just past the last winner so it gets lowest priority next round.
  always_comb begin
    sel   = grant_id_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(grant_id_q) + k) % NUM_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        sel   = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = '0;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    grant_id_d = grant_id_q;
    cnt_d      = cnt_q;
    timeout    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
          tx_data_d  = bus.req_data[int'(sel)*DATA_BITS +: DATA_BITS];
          grant_id_d = sel;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        tx_start_d = 1'b1;
        cnt_d      = '0;
        state_d    = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A done pulse takes precedence over a watchdog expiry in the same cycle.
        if (bus.tx_done_tick) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      grant_id_q <= IDW'(NUM_REQ - 1);
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      grant_id_q <= grant_id_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.busy        = busy_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.err_timeout = err_q;
endmodule
